spi_slave: RTL and testbench

SPI slave (peripheral) endpoint that receives bytes on MOSI and returns bytes on MISO. Wire-compatible with the team's SPI master in all four SPI modes. The slave runs entirely in the i_Clk domain and oversamples the SPI pins through synchronizers. It sits between an external SPI pin group and a byte-wide valid/ready user interface, and supports multi-byte transfers within one chip-select window.

---
 rtl/spi_slave_if.sv | 20 ++
 rtl/spi_slave.sv | 128 ++++++++++++
 tb/tb_spi_slave.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - byte-wide user side of the SPI slave
`timescale 1ns/1ps
interface spi_slave_if;
  logic [7:0] i_TX_Byte;
  logic       i_TX_DV;
  logic       o_TX_Ready;
  logic       o_TX_Underrun;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;

  modport slave (
    input  i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte
  );

  modport master (
    output i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI slave, all four modes, byte RX/TX
`timescale 1ns/1ps
module spi_slave #(
  parameter int         SPI_MODE   = 0,
  parameter logic [7:0] DEFAULT_TX = 8'h00
) (
  input  logic  i_Clk,
  input  logic  i_Rst_L,
  spi_slave_if.slave io_bus,
  input  logic  i_SPI_Clk,
  input  logic  i_SPI_CS_n,
  input  logic  i_SPI_MOSI,
  output logic  o_SPI_MISO,
  output logic  o_SPI_MISO_En
);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  // [0],[1] synchronizer stages, [2] previous value for edge detect
  logic [2:0] r_clk_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;

  logic [7:0] r_rx_shift;
  logic [2:0] r_rx_cnt;
  logic [7:0] r_rx_byte;
  logic       r_rx_dv;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_cnt;
  logic [7:0] r_hold;
  logic       r_tx_ready;
  logic       r_tx_underrun;
  logic       r_miso;

  logic       w_sel, w_clk_rise, w_clk_fall, w_lead, w_trail;
  logic       w_sample, w_shift, w_cs_fall, w_cs_rise, w_load, w_mosi;
  logic [7:0] w_load_byte;
  logic [2:0] w_bit_idx;

  assign w_sel      = ~r_cs_sync[1];
  assign w_mosi     = r_mosi_sync[1];
  assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_clk_fall = ~r_clk_sync[1] & r_clk_sync[2];
  assign w_lead     = CPOL ? w_clk_fall : w_clk_rise;
  assign w_trail    = CPOL ? w_clk_rise : w_clk_fall;
  assign w_sample   = w_sel & (CPHA ? w_trail : w_lead);
  assign w_shift    = w_sel & (CPHA ? w_lead : w_trail);
  assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];

  // CPHA=0 presents bit 7 before the first clock, so loads happen at CS fall
  // and on the byte-closing shift edge; CPHA=1 loads on the byte's first shift.
  assign w_load = CPHA ? (w_shift && (r_tx_cnt == 3'd7))
                       : (w_cs_fall || (w_shift && (r_tx_cnt == 3'd0)));

  // A TX byte arriving in the same cycle as a load skips the holding register
  assign w_load_byte = !r_tx_ready     ? r_hold :
                       io_bus.i_TX_DV ? io_bus.i_TX_Byte : DEFAULT_TX;

  // r_tx_cnt holds the next bit index (CPHA=1) or the bit on MISO (CPHA=0)
  assign w_bit_idx = CPHA ? r_tx_cnt : (r_tx_cnt - 3'd1);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_clk_sync    <= {3{CPOL}};
      r_cs_sync     <= 3'b111;
      r_mosi_sync   <= 2'b00;
      r_rx_shift    <= 8'h00;
      r_rx_cnt      <= 3'd7;
      r_rx_byte     <= 8'h00;
      r_rx_dv       <= 1'b0;
      r_tx_shift    <= 8'h00;
      r_tx_cnt      <= 3'd7;
      r_hold        <= 8'h00;
      r_tx_ready    <= 1'b1;
      r_tx_underrun <= 1'b0;
      r_miso        <= 1'b0;
    end else begin
      r_clk_sync    <= {r_clk_sync[1:0], i_SPI_Clk};
      r_cs_sync     <= {r_cs_sync[1:0], i_SPI_CS_n};
      r_mosi_sync   <= {r_mosi_sync[0], i_SPI_MOSI};
      r_rx_dv       <= 1'b0;
      r_tx_underrun <= 1'b0;

      if (w_cs_rise) begin
        r_rx_cnt   <= 3'd7;
        r_tx_cnt   <= 3'd7;
        r_rx_shift <= 8'h00;
        r_miso     <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_shift[r_rx_cnt] <= w_mosi;
          r_rx_cnt             <= r_rx_cnt - 3'd1;
          if (r_rx_cnt == 3'd0) begin
            r_rx_byte <= {r_rx_shift[7:1], w_mosi};
            r_rx_dv   <= 1'b1;
          end
        end
        if (w_load) begin
          r_tx_shift <= w_load_byte;
          r_miso     <= w_load_byte[7];
          r_tx_cnt   <= CPHA ? 3'd6 : 3'd7;
        end else if (w_shift) begin
          r_miso   <= r_tx_shift[w_bit_idx];
          r_tx_cnt <= r_tx_cnt - 3'd1;
        end
      end

      if (w_load) begin
        if (!r_tx_ready) begin
          r_tx_ready <= 1'b1;
        end else if (!io_bus.i_TX_DV) begin
          r_tx_underrun <= 1'b1;
        end
      end else if (io_bus.i_TX_DV && r_tx_ready) begin
        r_hold     <= io_bus.i_TX_Byte;
        r_tx_ready <= 1'b0;
      end
    end
  end

  assign io_bus.o_TX_Ready    = r_tx_ready;
  assign io_bus.o_TX_Underrun = r_tx_underrun;
  assign io_bus.o_RX_DV       = r_rx_dv;
  assign io_bus.o_RX_Byte     = r_rx_byte;
  assign o_SPI_MISO           = r_miso;
  assign o_SPI_MISO_En        = w_sel;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench, one slave instance per SPI mode
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_l;
  logic [3:0]      spi_clk, cs_n, mosi, tx_dv;
  logic [3:0][7:0] tx_byte;
  wire  [3:0]      tx_ready, tx_underrun, rx_dv, miso, miso_en;
  wire  [3:0][7:0] rx_byte;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_if bus ();
    assign bus.i_TX_Byte  = tx_byte[g];
    assign bus.i_TX_DV    = tx_dv[g];
    assign tx_ready[g]    = bus.o_TX_Ready;
    assign tx_underrun[g] = bus.o_TX_Underrun;
    assign rx_dv[g]       = bus.o_RX_DV;
    assign rx_byte[g]     = bus.o_RX_Byte;

    spi_slave #(.SPI_MODE(g), .DEFAULT_TX(8'h5A)) u_dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_l),
      .io_bus        (bus),
      .i_SPI_Clk     (spi_clk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  typedef struct { int mode; logic [7:0] b; } rx_exp_t;
  rx_exp_t    rx_q[$];
  logic [7:0] miso_q[$];
  rx_exp_t    mon_e;
  int uf_cnt[4] = '{default: 0};
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (tx_underrun[m]) uf_cnt[m]++;
      if (rx_dv[m]) begin
        chk("rx_pending", 32'(rx_q.size() != 0), 1);
        if (rx_q.size() != 0) begin
          mon_e = rx_q.pop_front();
          chk("rx_mode", m, mon_e.mode);
          chk("rx_byte", rx_byte[m], mon_e.b);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int m, input logic [7:0] b);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    tick(1);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(input int m);
    tick(H);
    cs_n[m] = 1'b1;
    tick(4 * H);
  endtask

  // Master side of one byte (or the first nbits of it)
  task automatic xfer(input int m, input logic [7:0] mo, input logic [7:0] exp_mi, input int nbits);
    logic       cpol, cpha;
    logic [7:0] mi;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi   = 8'h00;
    if (nbits == 8) begin
      rx_q.push_back('{m, mo});
      miso_q.push_back(exp_mi);
    end
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = mo[i];
        tick(H);
        mi[i] = miso[m];
        spi_clk[m] = ~cpol;
        tick(H);
        chk("miso_stable", miso[m], mi[i]);
        spi_clk[m] = cpol;
      end else begin
        spi_clk[m] = ~cpol;
        mosi[m] = mo[i];
        tick(H);
        mi[i] = miso[m];
        spi_clk[m] = cpol;
        tick(H);
        chk("miso_stable", miso[m], mi[i]);
      end
    end
    if (nbits == 8) chk("miso_byte", mi, miso_q.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int k;
    rst_l   = 1'b0;
    spi_clk = 4'b1100;
    cs_n    = 4'hF;
    mosi    = 4'h0;
    tx_dv   = 4'h0;
    tx_byte = '0;
    tick(3);
    for (int m = 0; m < 4; m++) begin
      chk("rst_ready", tx_ready[m], 1);
      chk("rst_underrun", tx_underrun[m], 0);
      chk("rst_rx_dv", rx_dv[m], 0);
      chk("rst_rx_byte", rx_byte[m], 8'h00);
      chk("rst_miso", miso[m], 0);
      chk("rst_miso_en", miso_en[m], 0);
    end
    rst_l = 1'b1;
    tick(4);

    // Mode 0: preloaded byte returned, ready restored at CS fall
    preload(0, 8'hA5);
    chk("m0_ready_after_dv", tx_ready[0], 0);
    u0 = uf_cnt[0];
    cs_low(0);
    chk("m0_ready_cs_fall", tx_ready[0], 1);
    chk("m0_no_uf_cs_fall", uf_cnt[0] - u0, 0);
    chk("m0_miso_en", miso_en[0], 1);
    chk("m0_miso_bit7", miso[0], 1);
    xfer(0, 8'h3C, 8'hA5, 8);
    cs_high(0);
    chk("m0_miso_en_off", miso_en[0], 0);
    chk("m0_miso_idle", miso[0], 0);
    chk("m0_rx_done", rx_q.size(), 0);

    // Mode 3: two bytes in one CS window, second TX byte loaded on ready
    preload(3, 8'h12);
    u0 = uf_cnt[3];
    cs_low(3);
    fork
      begin
        xfer(3, 8'h81, 8'h12, 8);
        xfer(3, 8'h7E, 8'h34, 8);
      end
      begin
        k = 0;
        while (!tx_ready[3] && k < 500) begin
          tick(1);
          k++;
        end
        chk("m3_ready_wait", tx_ready[3], 1);
        preload(3, 8'h34);
      end
    join
    cs_high(3);
    chk("m3_no_underrun", uf_cnt[3] - u0, 0);
    chk("m3_ready_end", tx_ready[3], 1);
    chk("m3_rx_done", rx_q.size(), 0);

    // Modes 1 and 2: all-ones / all-zeros exchange
    preload(1, 8'h00);
    cs_low(1);
    xfer(1, 8'hFF, 8'h00, 8);
    cs_high(1);
    preload(2, 8'hFF);
    cs_low(2);
    xfer(2, 8'h00, 8'hFF, 8);
    cs_high(2);
    chk("m12_rx_done", rx_q.size(), 0);

    // Underrun: nothing held, DEFAULT_TX goes out
    u0 = uf_cnt[0];
    cs_low(0);
    chk("uf_at_cs_fall", uf_cnt[0] - u0, 1);
    xfer(0, 8'h11, 8'h5A, 8);
    cs_high(0);

    // Partial byte discarded by CS rise
    cs_low(0);
    xfer(0, 8'hF0, 8'h00, 5);
    cs_high(0);
    chk("partial_no_dv", rx_q.size(), 0);
    chk("partial_rx_held", rx_byte[0], 8'h11);
    cs_low(0);
    xfer(0, 8'hC3, 8'h5A, 8);
    cs_high(0);

    // Reset mid-byte, then a clean transfer
    cs_low(0);
    preload(0, 8'h77);
    xfer(0, 8'h0F, 8'h00, 4);
    rst_l = 1'b0;
    tick(2);
    chk("mid_rst_ready", tx_ready[0], 1);
    chk("mid_rst_underrun", tx_underrun[0], 0);
    chk("mid_rst_rx_dv", rx_dv[0], 0);
    chk("mid_rst_rx_byte", rx_byte[0], 8'h00);
    chk("mid_rst_miso", miso[0], 0);
    chk("mid_rst_miso_en", miso_en[0], 0);
    cs_n[0] = 1'b1;
    tick(4);
    rst_l = 1'b1;
    tick(4 * H);
    cs_low(0);
    xfer(0, 8'h99, 8'h5A, 8);
    cs_high(0);

    chk("rx_drained", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
